// File: rtl/pipe_pkg.sv
// Shared pipeline types: the execute-stage payload and the skid-buffer state encoding.
package pipe_pkg;

    localparam int PKG_DATA_W    = 64;
    localparam int PKG_ADDR_W    = 64;
    localparam int PKG_REG_ADDR_W = 5;
    localparam int PKG_RES_SRC_W = 3;

    typedef struct packed {
        logic [PKG_RES_SRC_W-1:0]  result_src;
        logic                      mem_we;
        logic                      reg_we;
        logic [PKG_ADDR_W-1:0]     pc_plus4;
        logic [PKG_ADDR_W-1:0]     pc_target;
        logic [PKG_DATA_W-1:0]     imm_ext;
        logic [PKG_DATA_W-1:0]     alu_result;
        logic [PKG_DATA_W-1:0]     write_data;
        logic [PKG_REG_ADDR_W-1:0] rd_addr;
    } ex_payload_t;

    localparam int EX_PAYLOAD_W = $bits(ex_payload_t);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage : pipe_pkg

// File: rtl/preg_skid.sv
// Generic 2-slot skid buffer: registered ready, main slot drives the output,
// skid slot absorbs the one beat accepted while downstream stalls.
module preg_skid
    import pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_arstn,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    skid_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             ready_q;
    logic             push, pop;

    assign o_valid = (state_q != EMPTY);
    assign o_ready = ready_q;
    assign o_data  = main_q;
    assign push    = i_valid & ready_q;
    assign pop     = o_valid & i_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    main_d  = i_data;
                end
            end
            ONE: begin
                if (push && pop) begin
                    main_d = i_data;
                end else if (pop) begin
                    state_d = EMPTY;
                end else if (push) begin
                    state_d = FULL;
                    skid_d  = i_data;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Squash wins over any concurrent push or pop; stale data bits are harmless.
        if (i_flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= (state_d != FULL);
        end
    end

endmodule : preg_skid

// File: rtl/preg_execute_skid.sv
// Execute-to-memory pipeline register: packs the execute payload through a skid
// buffer and gates the write enables with the output valid.
module preg_execute_skid
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = PKG_DATA_W,
    parameter int ADDR_WIDTH = PKG_ADDR_W,
    parameter int REG_ADDR_W = PKG_REG_ADDR_W,
    parameter int RES_SRC_W  = PKG_RES_SRC_W
) (
    input  logic                  i_clk,
    input  logic                  i_arstn,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_flush,
    input  logic [RES_SRC_W-1:0]  i_result_src,
    input  logic                  i_mem_we,
    input  logic                  i_reg_we,
    input  logic [ADDR_WIDTH-1:0] i_pc_plus4,
    input  logic [ADDR_WIDTH-1:0] i_pc_target,
    input  logic [DATA_WIDTH-1:0] i_imm_ext,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [RES_SRC_W-1:0]  o_result_src,
    output logic                  o_mem_we,
    output logic                  o_reg_we,
    output logic [ADDR_WIDTH-1:0] o_pc_plus4,
    output logic [ADDR_WIDTH-1:0] o_pc_target,
    output logic [DATA_WIDTH-1:0] o_imm_ext,
    output logic [DATA_WIDTH-1:0] o_alu_result,
    output logic [DATA_WIDTH-1:0] o_write_data,
    output logic [REG_ADDR_W-1:0] o_rd_addr
);

    ex_payload_t in_pl;
    ex_payload_t out_pl;
    logic [EX_PAYLOAD_W-1:0] out_vec;

    // Field widths come from the shared payload type; parameters must match it.
    always_comb begin
        in_pl            = '0;
        in_pl.result_src = i_result_src;
        in_pl.mem_we     = i_mem_we;
        in_pl.reg_we     = i_reg_we;
        in_pl.pc_plus4   = i_pc_plus4;
        in_pl.pc_target  = i_pc_target;
        in_pl.imm_ext    = i_imm_ext;
        in_pl.alu_result = i_alu_result;
        in_pl.write_data = i_write_data;
        in_pl.rd_addr    = i_rd_addr;
    end

    preg_skid #(
        .WIDTH (EX_PAYLOAD_W)
    ) u_skid (
        .i_clk   (i_clk),
        .i_arstn (i_arstn),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (in_pl),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (out_vec)
    );

    assign out_pl       = ex_payload_t'(out_vec);
    assign o_result_src = out_pl.result_src;
    assign o_pc_plus4   = out_pl.pc_plus4;
    assign o_pc_target  = out_pl.pc_target;
    assign o_imm_ext    = out_pl.imm_ext;
    assign o_alu_result = out_pl.alu_result;
    assign o_write_data = out_pl.write_data;
    assign o_rd_addr    = out_pl.rd_addr;

    // A bubble (including one left by a flush) must never write memory or the register file.
    assign o_mem_we     = out_pl.mem_we & o_valid;
    assign o_reg_we     = out_pl.reg_we & o_valid;

endmodule : preg_execute_skid

// File: doc/preg_execute_skid.md
Name: preg_execute_skid

Overview:
- Execute-to-memory pipeline register with a valid/ready handshake and a 2-entry skid buffer.
- Replaces the plain always-load execute register so that memory-stage backpressure can stall execute without a combinational ready path.
- Supports a synchronous flush for branch and exception squash.
- Sits between the ALU/branch-target logic and the memory stage.

Parameters:
- DATA_WIDTH, 64, width of imm_ext, alu_result, write_data.
- ADDR_WIDTH, 64, width of pc_plus4, pc_target.
- REG_ADDR_W, 5, destination register index width.
- RES_SRC_W, 3, width of result_src select.

Ports:
- i_clk  in  1  clock, rising edge.
- i_arstn  in  1  asynchronous active-low reset.
- i_valid  in  1  upstream beat valid.
- o_ready  out  1  block can accept a beat; driven directly from a flop.
- i_flush  in  1  synchronous squash of all held beats.
- i_result_src  in  RES_SRC_W  writeback select.
- i_mem_we  in  1  memory write enable.
- i_reg_we  in  1  register-file write enable.
- i_pc_plus4  in  ADDR_WIDTH  PC+4.
- i_pc_target  in  ADDR_WIDTH  branch/jump target.
- i_imm_ext  in  DATA_WIDTH  extended immediate.
- i_alu_result  in  DATA_WIDTH  ALU result.
- i_write_data  in  DATA_WIDTH  store data.
- i_rd_addr  in  REG_ADDR_W  destination register.
- o_valid  out  1  downstream beat valid.
- i_ready  in  1  downstream accepts.
- o_result_src, o_mem_we, o_reg_we, o_pc_plus4, o_pc_target, o_imm_ext, o_alu_result, o_write_data, o_rd_addr  out  matching widths  registered payload.

Behaviour:
- Reset: i_arstn low asynchronously clears both slots.
  - o_valid=0, every payload output=0, o_mem_we=0, o_reg_we=0.
  - o_ready=1, state EMPTY.
- Handshake: push = i_valid & o_ready; pop = o_valid & i_ready.
  - Payload is held stable while o_valid=1 and i_ready=0.
- Storage: main slot drives the outputs; the skid slot holds a beat accepted while downstream stalled.
- States:
  - EMPTY (o_valid=0, o_ready=1):
    - push -> ONE; main loads input.
    - otherwise stay.
  - ONE (o_valid=1, o_ready=1):
    - push & pop -> ONE; main loads input.
    - pop only -> EMPTY.
    - push & !pop -> FULL; skid loads input.
    - neither -> stay.
  - FULL (o_valid=1, o_ready=0):
    - pop -> ONE; main loads skid.
    - otherwise stay.
    - i_valid is ignored because o_ready=0.
- Latency: 1 cycle input-to-output from EMPTY or ONE. Sustained throughput is 1 beat/cycle while i_ready=1.
- o_ready is a flop, equal to (next state != FULL). There is no combinational path from i_ready to o_ready.
- Flush:
  - i_flush=1 at a clock edge -> next state EMPTY and o_ready=1.
  - A push in the same cycle is dropped; flush has priority over push and pop.
  - Payload data bits need not clear, but o_mem_we and o_reg_we must read 0 the cycle after.
- Write-enable gating: o_mem_we = main.mem_we & o_valid; o_reg_we = main.reg_we & o_valid. No store or register write may escape on a bubble.
- Every payload field, including reg_we, is captured from its own input. No field may recirculate its own output.
- Reset deassertion mid-stream: the first edge after i_arstn rises behaves as EMPTY.

Decomposition:
- Shared package pipe_pkg:
  - typedef ex_payload_t, a packed struct of all payload fields sized by the parameters.
  - localparam enum skid_state_t {EMPTY, ONE, FULL}.
- Sub-module preg_skid: generic 2-slot skid buffer on a WIDTH-bit vector with valid/ready/flush.
  - The top packs the inputs into ex_payload_t, instantiates preg_skid, unpacks the result, and applies the write-enable gating.

Test Plan:
- Reset: hold i_arstn=0 with i_valid=1 and non-zero payload -> o_valid=0, all outputs 0, o_ready=1. Release; push alu_result=0x1234 -> o_alu_result=0x1234 and o_valid=1 one cycle later.
- Streaming: i_ready=1, push 8 consecutive beats with rd_addr=1..8 -> the outputs show rd_addr 1..8 on 8 consecutive cycles with no bubbles; o_ready stays 1.
- Stall/skid:
  - Push beats A (rd=3) and B (rd=4) while i_ready=0 -> o_ready falls to 0 after B is accepted; output holds A.
  - Raise i_ready -> A, then B, pop on consecutive cycles; o_ready returns to 1.
  - C offered while o_ready=0 is not accepted.
- Flush in FULL: with A and B held, assert i_flush together with a push of C -> next cycle o_valid=0, o_mem_we=0, o_reg_we=0, o_ready=1; C never appears.
- Write-enable gating: push mem_we=1, reg_we=1, then let it pop with no further push -> in the following cycle o_valid=0 and o_mem_we=o_reg_we=0.
- Asynchronous reset mid-operation: assert i_arstn low between edges while in FULL -> outputs clear immediately without a clock edge; state is EMPTY after release.
